// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, waits out the instruction memory delay and
// hands the captured word to decode over valid/ready. Optional IFU_ALIGN_CHECK_EN
// rejects misaligned redirects and raises a sticky misalign_err.
module instruction_fetch_unit #(
    parameter int unsigned MEM_LATENCY = 100,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misalign_err
);

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);

    typedef enum logic {
        S_WAIT = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [AW-1:0] instr_nxt, instr_pc_nxt;
    logic          valid_nxt, err_nxt;
    logic          redirect_ok_c;
    logic [AW-1:0] target_c;

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_WAIT;
            pc           <= RESET_PC;
            cnt          <= LAT;
            instr        <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            cnt          <= cnt_nxt;
            instr        <= instr_nxt;
            instr_pc     <= instr_pc_nxt;
            instr_valid  <= valid_nxt;
            misalign_err <= err_nxt;
        end
    end

    // Next-state logic: an accepted redirect outranks both capture and handshake.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        cnt_nxt      = cnt;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;
        valid_nxt    = instr_valid;
        err_nxt      = misalign_err;

`ifdef IFU_ALIGN_CHECK_EN
        redirect_ok_c = redirect && (redirect_pc[1:0] == 2'b00);
        if (redirect && !redirect_ok_c) begin
            err_nxt = 1'b1;
        end
`else
        redirect_ok_c = redirect;
`endif
        target_c = redirect_pc & ~AW'(3);

        if (redirect_ok_c) begin
            pc_nxt    = target_c;
            cnt_nxt   = LAT;
            valid_nxt = 1'b0;
            state_nxt = S_WAIT;
        end else begin
            case (state)
                S_WAIT: begin
                    cnt_nxt = cnt - CW'(1);
                    if (cnt <= CW'(1)) begin
                        instr_nxt    = imem_instr;
                        instr_pc_nxt = pc;
                        valid_nxt    = 1'b1;
                        state_nxt    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        pc_nxt    = pc + AW'(4);
                        cnt_nxt   = LAT;
                        valid_nxt = 1'b0;
                        state_nxt = S_WAIT;
                    end
                end
                default: state_nxt = S_WAIT;
            endcase
        end
    end

    assign imem_addr = pc;

endmodule
